store_retire_buffer: RTL and testbench

- Receives retired stores from the retire stage on the store2Dmem interface: command, size, address, data.
- Holds them in an in-order FIFO and drains them to the data-memory bus, arbitrating against the load unit.
- Sits between retire and Dmem, so retire never waits on memory latency.
- Provides combinational store-to-load forwarding / conflict detection so loads never read stale memory.

---
 rtl/store_retire_buffer.sv | 104 ++++++++++
 tb/tb_store_retire_buffer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_retire_buffer.sv
// store_retire_buffer: in-order retired-store FIFO draining to Dmem with store-to-load forwarding
`ifndef XLEN
`define XLEN 32
`endif
module store_retire_buffer #(
  parameter int SB_DEPTH = 8,
  parameter bit SB_FULL_PRIO = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        store2Dmem_command,
  input  logic [1:0]        store2Dmem_size,
  input  logic [`XLEN-1:0]  store2Dmem_addr,
  input  logic [`XLEN-1:0]  store2Dmem_data,
  output logic              sb_full,
  output logic              sb_empty,
  input  logic              load_req,
  input  logic [`XLEN-1:0]  load_addr,
  input  logic [1:0]        load_size,
  output logic              load_grant,
  output logic              fwd_hit,
  output logic [`XLEN-1:0]  fwd_data,
  output logic              fwd_stall,
  output logic [1:0]        proc2mem_command,
  output logic [`XLEN-1:0]  proc2mem_addr,
  output logic [63:0]       proc2mem_data,
  output logic [1:0]        proc2mem_size,
  input  logic [3:0]        mem2proc_response
);
  localparam logic [1:0] BUS_NONE = 2'd0, BUS_LOAD = 2'd1, BUS_STORE = 2'd2;
  localparam logic [1:0] MEM_BYTE = 2'd0, MEM_HALF = 2'd1;
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic {SB_IDLE, SB_DRAIN} state_t;
  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
    return size == MEM_BYTE ? 4'b0001 << off : size == MEM_HALF ? 4'b0011 << off : 4'b1111;
  endfunction
  state_t state;
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count, count_next;
  logic [`XLEN-1:0] ent_addr [SB_DEPTH];
  logic [`XLEN-1:0] ent_data [SB_DEPTH];
  logic [1:0] ent_size [SB_DEPTH];
  logic enq, pop, store_sel;
  logic [3:0] load_mask;
  logic [SB_DEPTH-1:0] ovl, cov;
  logic [`XLEN-1:0] shd [SB_DEPTH];
  assign enq = store2Dmem_command == BUS_STORE && !sb_full;
  assign store_sel = state == SB_DRAIN && (!load_req || (SB_FULL_PRIO && sb_full));
  assign load_grant = load_req && !store_sel;
  assign pop = store_sel && |mem2proc_response;
  assign count_next = count + CW'(enq) - CW'(pop);
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= SB_IDLE;
      head <= '0;
      tail <= '0;
      count <= '0;
      sb_full <= 1'b0;
      sb_empty <= 1'b1;
    end else begin
      if (enq) begin
        ent_addr[tail] <= store2Dmem_addr;
        ent_size[tail] <= store2Dmem_size;
        ent_data[tail] <= store2Dmem_data;
        tail <= tail + PW'(1);
      end
      if (pop) head <= head + PW'(1);
      count <= count_next;
      sb_full <= count_next == CW'(SB_DEPTH);
      sb_empty <= count_next == '0;
      state <= count_next == '0 ? SB_IDLE : SB_DRAIN;
    end
  end
  assert property (@(posedge clock) disable iff (reset) !(store2Dmem_command == BUS_STORE && sb_full));
  always_comb begin
    proc2mem_command = store_sel ? BUS_STORE : load_grant ? BUS_LOAD : BUS_NONE;
    proc2mem_addr = store_sel ? ent_addr[head] : load_grant ? load_addr : '0;
    proc2mem_size = store_sel ? ent_size[head] : load_grant ? load_size : '0;
    proc2mem_data = store_sel ? 64'(ent_data[head]) : '0;
  end
  assign load_mask = byte_mask(load_size, load_addr[1:0]);
  // i is age order: 0 is the head (oldest), higher i is younger
  for (genvar i = 0; i < SB_DEPTH; i++) begin : g_fwd
    logic [PW-1:0] idx;
    logic [3:0] m;
    assign idx = head + PW'(i);
    assign m = byte_mask(ent_size[idx], ent_addr[idx][1:0]) & load_mask;
    assign ovl[i] = CW'(i) < count && ent_addr[idx][`XLEN-1:2] == load_addr[`XLEN-1:2] && |m;
    assign cov[i] = m == load_mask;
    assign shd[i] = ent_data[idx] >> {load_addr[1:0] - ent_addr[idx][1:0], 3'b000};
  end
  always_comb begin
    fwd_hit = 1'b0;
    fwd_stall = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < SB_DEPTH; k++)
      if (ovl[k]) begin
        fwd_hit = cov[k];
        fwd_stall = !cov[k];
        fwd_data = cov[k] ? shd[k] : '0;
      end
  end
endmodule

// File: tb/tb_store_retire_buffer.sv
// tb_store_retire_buffer: directed vector table, corner sequences and random traffic vs a queue model
`ifndef XLEN
`define XLEN 32
`endif
module tb_store_retire_buffer;
  localparam int D = 8;
  localparam logic [1:0] NONE = 2'd0, LOAD = 2'd1, STORE = 2'd2;
  localparam logic [1:0] BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2;
  logic clock = 1'b0, reset = 1'b1;
  logic [1:0] store2Dmem_command = NONE, store2Dmem_size = BYTE;
  logic [31:0] store2Dmem_addr = '0, store2Dmem_data = '0;
  logic sb_full, sb_empty, load_req = 1'b0, load_grant, fwd_hit, fwd_stall;
  logic [31:0] load_addr = '0, fwd_data, proc2mem_addr;
  logic [1:0] load_size = BYTE, proc2mem_command, proc2mem_size;
  logic [63:0] proc2mem_data;
  logic [3:0] mem2proc_response = '0;
  always #5 clock = ~clock;
  store_retire_buffer #(.SB_DEPTH(D), .SB_FULL_PRIO(1'b1)) dut (
    .clock(clock), .reset(reset),
    .store2Dmem_command(store2Dmem_command), .store2Dmem_size(store2Dmem_size),
    .store2Dmem_addr(store2Dmem_addr), .store2Dmem_data(store2Dmem_data),
    .sb_full(sb_full), .sb_empty(sb_empty),
    .load_req(load_req), .load_addr(load_addr), .load_size(load_size), .load_grant(load_grant),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .proc2mem_size(proc2mem_size),
    .mem2proc_response(mem2proc_response)
  );
  typedef struct { logic [31:0] addr; logic [1:0] size; logic [31:0] data; } st_t;
  typedef struct {
    logic [1:0] cmd; logic [1:0] size; logic [31:0] addr; logic [31:0] data;
    logic lreq; logic [31:0] la; logic [1:0] ls; logic [3:0] resp;
    logic [1:0] e_cmd; logic [31:0] e_addr; logic [63:0] e_data; logic e_grant; logic e_hit;
    logic [31:0] e_fwd; logic e_stall; logic e_empty; logic e_full;
  } vec_t;
  st_t q[$];
  vec_t tbl [11];
  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] c, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d,
                       input logic lr, input logic [31:0] la, input logic [1:0] ls, input logic [3:0] r);
    store2Dmem_command = c; store2Dmem_size = s; store2Dmem_addr = a; store2Dmem_data = d;
    load_req = lr; load_addr = la; load_size = ls; mem2proc_response = r;
    #1;
  endtask

  function automatic longint nb(input logic [1:0] s);
    return s == BYTE ? 1 : s == HALF ? 2 : 4;
  endfunction

  // Expected outputs from byte-range arithmetic over the queue, youngest overlapping store wins
  task automatic model_check();
    bit full, empty, ss, found;
    logic hit, stall;
    logic [31:0] fd;
    st_t h;
    longint sa, sn, la, ln;
    full = q.size() == D; empty = q.size() == 0;
    ss = !empty && (!load_req || full);
    h.addr = '0; h.size = '0; h.data = '0;
    if (!empty) h = q[0];
    hit = 1'b0; stall = 1'b0; fd = '0; found = 1'b0;
    la = longint'(load_addr); ln = nb(load_size);
    for (int i = q.size() - 1; i >= 0 && !found; i--) begin
      sa = longint'(q[i].addr); sn = nb(q[i].size);
      if (sa < la + ln && la < sa + sn) begin
        found = 1'b1;
        if (sa <= la && la + ln <= sa + sn) begin
          hit = 1'b1;
          fd = q[i].data >> (8 * (la - sa));
        end else stall = 1'b1;
      end
    end
    chk("sb_full", sb_full, full);
    chk("sb_empty", sb_empty, empty);
    chk("bus_cmd", proc2mem_command, ss ? STORE : load_req ? LOAD : NONE);
    chk("bus_addr", proc2mem_addr, ss ? h.addr : load_req ? load_addr : 32'h0);
    chk("bus_size", proc2mem_size, ss ? h.size : load_req ? load_size : 2'd0);
    chk("bus_data", proc2mem_data, ss ? {32'h0, h.data} : 64'h0);
    chk("load_grant", load_grant, load_req && !ss);
    chk("fwd_hit", fwd_hit, hit);
    chk("fwd_data", fwd_data, fd);
    chk("fwd_stall", fwd_stall, stall);
  endtask

  task automatic edge_step();
    bit full, ss, p, e;
    st_t n;
    full = q.size() == D;
    ss = q.size() != 0 && (!load_req || full);
    p = ss && mem2proc_response != 0;
    e = store2Dmem_command == STORE && !full;
    n.addr = store2Dmem_addr; n.size = store2Dmem_size; n.data = store2Dmem_data;
    @(posedge clock);
    if (p) void'(q.pop_front());
    if (e) q.push_back(n);
    #1;
  endtask

  task automatic cycle(input logic [1:0] c, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d,
                       input logic lr, input logic [31:0] la, input logic [1:0] ls, input logic [3:0] r);
    drive(c, s, a, d, lr, la, ls, r);
    model_check();
    edge_step();
  endtask

  task automatic do_reset();
    drive(NONE, BYTE, '0, '0, 1'b0, '0, BYTE, '0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    q.delete();
  endtask

  task automatic drain();
    for (int k = 0; k < 4 * D && q.size() != 0; k++)
      cycle(NONE, BYTE, '0, '0, 1'b0, 32'h8000, WORD, 4'd1);
    drive(NONE, BYTE, '0, '0, 1'b0, 32'h8000, WORD, 4'd0);
    chk("drained_empty", sb_empty, 1'b1);
  endtask

  function automatic logic [31:0] rand_addr(input logic [1:0] s);
    logic [31:0] b;
    b = 32'h5000 + 32'($urandom_range(3)) * 4;
    return b + (s == BYTE ? 32'($urandom_range(3)) : s == HALF ? 32'($urandom_range(1)) * 2 : 32'h0);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{NONE, BYTE, '0, '0, 1'b1, 32'h3000, WORD, 4'd0,
                LOAD, 32'h3000, 64'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{STORE, WORD, 32'h1000, 32'hDEADBEEF, 1'b0, '0, BYTE, 4'd3,
                NONE, 32'h0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{NONE, BYTE, '0, '0, 1'b0, '0, BYTE, 4'd3,
                STORE, 32'h1000, 64'h00000000DEADBEEF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{NONE, BYTE, '0, '0, 1'b0, '0, BYTE, 4'd0,
                NONE, 32'h0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{STORE, WORD, 32'h2000, 32'h11223344, 1'b0, '0, BYTE, 4'd0,
                NONE, 32'h0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{STORE, BYTE, 32'h2001, 32'h000000AA, 1'b0, 32'h2001, BYTE, 4'd0,
                STORE, 32'h2000, 64'h11223344, 1'b0, 1'b1, 32'h00112233, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{NONE, BYTE, '0, '0, 1'b0, 32'h2001, BYTE, 4'd0,
                STORE, 32'h2000, 64'h11223344, 1'b0, 1'b1, 32'h000000AA, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{NONE, BYTE, '0, '0, 1'b1, 32'h2000, WORD, 4'd0,
                LOAD, 32'h2000, 64'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{NONE, BYTE, '0, '0, 1'b0, 32'h2002, HALF, 4'd1,
                STORE, 32'h2000, 64'h11223344, 1'b0, 1'b1, 32'h00001122, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{NONE, BYTE, '0, '0, 1'b0, 32'h2000, HALF, 4'd1,
                STORE, 32'h2001, 64'h000000AA, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{NONE, BYTE, '0, '0, 1'b0, 32'h4000, WORD, 4'd0,
                NONE, 32'h0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].cmd, tbl[i].size, tbl[i].addr, tbl[i].data, tbl[i].lreq, tbl[i].la, tbl[i].ls, tbl[i].resp);
      chk($sformatf("v%0d_cmd", i), proc2mem_command, tbl[i].e_cmd);
      chk($sformatf("v%0d_addr", i), proc2mem_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_data", i), proc2mem_data, tbl[i].e_data);
      chk($sformatf("v%0d_grant", i), load_grant, tbl[i].e_grant);
      chk($sformatf("v%0d_hit", i), fwd_hit, tbl[i].e_hit);
      chk($sformatf("v%0d_fwd", i), fwd_data, tbl[i].e_fwd);
      chk($sformatf("v%0d_stall", i), fwd_stall, tbl[i].e_stall);
      chk($sformatf("v%0d_empty", i), sb_empty, tbl[i].e_empty);
      chk($sformatf("v%0d_full", i), sb_full, tbl[i].e_full);
      edge_step();
    end
    // fill with the bus refusing every request while a load keeps asking
    for (int k = 0; k < D; k++)
      cycle(STORE, WORD, 32'(32'h6000 + 4 * k), $urandom, 1'b1, 32'h9000, WORD, 4'd0);
    drive(NONE, BYTE, '0, '0, 1'b1, 32'h9000, WORD, 4'd0);
    model_check();
    chk("fill_full", sb_full, 1'b1);
    chk("fill_grant", load_grant, 1'b0);
    chk("fill_cmd", proc2mem_command, STORE);
    edge_step();
    cycle(NONE, BYTE, '0, '0, 1'b1, 32'h9000, WORD, 4'd2);
    drive(NONE, BYTE, '0, '0, 1'b1, 32'h9000, WORD, 4'd0);
    model_check();
    chk("unfull", sb_full, 1'b0);
    edge_step();
    drain();
    // pointer wrap with steady occupancy: enqueue and pop in the same cycle
    for (int k = 0; k < 5; k++)
      cycle(STORE, WORD, 32'(32'h7000 + 4 * k), 32'(k), 1'b0, 32'h9000, WORD, 4'd0);
    for (int k = 5; k < 5 + 3 * D; k++)
      cycle(STORE, WORD, 32'(32'h7000 + 4 * k), 32'(k), 1'b0, 32'h9000, WORD, 4'd1);
    drain();
    // reset while the head is being issued
    for (int k = 0; k < 4; k++)
      cycle(STORE, WORD, 32'(32'hA000 + 4 * k), 32'(k), 1'b0, 32'h9000, WORD, 4'd0);
    drive(NONE, BYTE, '0, '0, 1'b0, 32'hA000, WORD, 4'd3);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    q.delete();
    drive(NONE, BYTE, '0, '0, 1'b0, 32'hA000, WORD, 4'd3);
    chk("rst_empty", sb_empty, 1'b1);
    chk("rst_cmd", proc2mem_command, NONE);
    chk("rst_fwd_hit", fwd_hit, 1'b0);
    edge_step();
    for (int k = 0; k < 3; k++) cycle(NONE, BYTE, '0, '0, 1'b0, 32'hA000, WORD, 4'd3);
    // random traffic
    for (int k = 0; k < 3000; k++) begin
      logic [1:0] c, s, ls;
      int r;
      r = int'($urandom_range(9));
      c = r < 6 ? STORE : r < 8 ? NONE : LOAD;
      if (c == STORE && q.size() == D) c = NONE;
      s = 2'($urandom_range(2));
      ls = 2'($urandom_range(2));
      cycle(c, s, rand_addr(s), $urandom, 1'($urandom_range(1)), rand_addr(ls), ls,
            $urandom_range(1) ? 4'($urandom_range(15)) : 4'd0);
    end
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
